// File: rtl/fpu_wb_queue_if.sv
// Writeback queue bus: two result sources on the push side, one
// register-file write port on the drain side.
interface fpu_wb_queue_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);
  logic          a_flag;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_data;
  logic          b_flag;
  logic [AW-1:0] b_address;
  logic [DW-1:0] b_data;
  logic          wb_valid;
  logic [AW-1:0] wb_address;
  logic [DW-1:0] wb_data;
  logic          wb_ready;

  // Driver side: result sources and the register file
  modport master (
    output a_flag, a_address, a_data,
    output b_flag, b_address, b_data,
    output wb_ready,
    input  wb_valid, wb_address, wb_data
  );

  // Queue side
  modport slave (
    input  a_flag, a_address, a_data,
    input  b_flag, b_address, b_data,
    input  wb_ready,
    output wb_valid, wb_address, wb_data
  );
endinterface

// File: rtl/fpu_wb_queue.sv
// In-order writeback collector: accepts up to two FPU results per cycle
// into a circular buffer and drains one per cycle to the FP register file.
module fpu_wb_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  fpu_wb_queue_if.slave            bus,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [CW-1:0] space;
  logic [1:0]    n_req;
  logic [1:0]    acc;
  logic          drop;
  logic          pop;
  logic          we0;
  logic          we1;
  logic [AW-1:0] w0_addr;
  logic [DW-1:0] w0_data;
  logic [PW-1:0] wr_ptr1;
  logic [CW-1:0] count_next;

  // Push/pop decisions; free space is taken before this cycle's pop
  always_comb begin
    space      = CW'(DEPTH) - count;
    n_req      = 2'(bus.a_flag) + 2'(bus.b_flag);
    pop        = (count != '0) & bus.wb_ready;
    acc        = '0;
    we0        = 1'b0;
    we1        = 1'b0;
    wr_ptr1    = wr_ptr + PW'(1);
    w0_addr    = bus.a_flag ? bus.a_address : bus.b_address;
    w0_data    = bus.a_flag ? bus.a_data    : bus.b_data;
    if (CW'(n_req) <= space) begin
      acc = n_req;
      we0 = (n_req != '0);
      we1 = (n_req == 2'd2);
    end else if (space != '0) begin
      // Only reachable with both flags and one slot: the older result (A) wins
      acc = 2'd1;
      we0 = 1'b1;
    end
    drop       = (n_req != acc);
    count_next = count + CW'(acc) - CW'(pop);
  end

  // Storage array; never cleared, contents qualified by count
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we0) begin
        addr_mem[wr_ptr] <= w0_addr;
        data_mem[wr_ptr] <= w0_data;
      end
      if (we1) begin
        addr_mem[wr_ptr1] <= bus.b_address;
        data_mem[wr_ptr1] <= bus.b_data;
      end
    end
  end

  // Pointers, occupancy, sticky overflow and registered stall hint
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      stall    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(acc);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count_next;
      overflow <= overflow | drop;
      stall    <= (count_next >= CW'(DEPTH - 2));
    end
  end

  // Head of queue presented combinationally
  always_comb begin
    bus.wb_valid   = (count != '0);
    bus.wb_address = addr_mem[rd_ptr];
    bus.wb_data    = data_mem[rd_ptr];
  end
endmodule

// File: tb/tb_fpu_wb_queue.sv
// Directed self-checking bench for fpu_wb_queue.
module tb_fpu_wb_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic       clk;
  logic       rst;
  logic       stall;
  logic [3:0] count;
  logic       overflow;
  int         total;
  int         bad;
  int         max_cnt;

  fpu_wb_queue_if #(.AW(AW), .DW(DW)) bus ();

  fpu_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .stall    (stall),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.a_flag = 1'b1; bus.a_address = ad; bus.a_data = d;
  endtask

  task automatic idle_in();
    bus.a_flag = 1'b0; bus.b_flag = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_in(); step(); rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; max_cnt = 0;
    rst = 1'b1;
    bus.a_flag = 1'b0; bus.a_address = '0; bus.a_data = '0;
    bus.b_flag = 1'b0; bus.b_address = '0; bus.b_data = '0;
    bus.wb_ready = 1'b0;
    #1;
    step(); step();
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);

    // 1: single push, pop next cycle
    push_a(5'd3, 32'h3F800000); bus.wb_ready = 1'b1;
    step(); idle_in();
    check("t1_valid", 64'(bus.wb_valid), 64'd1);
    check("t1_addr", 64'(bus.wb_address), 64'd3);
    check("t1_data", 64'(bus.wb_data), 64'h3F800000);
    step();
    check("t1_empty_valid", 64'(bus.wb_valid), 64'd0);
    check("t1_empty_count", 64'(count), 64'd0);

    // 2: dual push, A drains before B
    bus.wb_ready = 1'b0;
    push_a(5'd5, 32'h40000000);
    bus.b_flag = 1'b1; bus.b_address = 5'd7; bus.b_data = 32'h40400000;
    step(); idle_in();
    check("t2_count", 64'(count), 64'd2);
    check("t2_head_addr", 64'(bus.wb_address), 64'd5);
    check("t2_head_data", 64'(bus.wb_data), 64'h40000000);
    bus.wb_ready = 1'b1;
    step();
    check("t2_second_addr", 64'(bus.wb_address), 64'd7);
    check("t2_second_data", 64'(bus.wb_data), 64'h40400000);
    step();
    check("t2_drained", 64'(count), 64'd0);

    // 3: fill without draining; entries 10..16
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push_a(AW'(10 + i), DW'(32'h100 + i));
      step();
      if (i == 4) check("t3_stall_at5", 64'(stall), 64'd0);
      if (i == 5) check("t3_stall_at6", 64'(stall), 64'd1);
    end
    check("t3_count7", 64'(count), 64'd7);
    check("t3_ovf_clear", 64'(overflow), 64'd0);
    push_a(5'd20, 32'h200);
    bus.b_flag = 1'b1; bus.b_address = 5'd21; bus.b_data = 32'h201;
    step(); bus.b_flag = 1'b0;
    check("t3_count8", 64'(count), 64'd8);
    check("t3_ovf_set", 64'(overflow), 64'd1);
    check("t3_stall_full", 64'(stall), 64'd1);
    push_a(5'd22, 32'h202);
    step();
    check("t3_count_stays8", 64'(count), 64'd8);
    check("t3_head", 64'(bus.wb_address), 64'd10);

    // 4: full with pop: push dropped, count falls to 7
    push_a(5'd23, 32'h203); bus.wb_ready = 1'b1;
    step(); idle_in();
    check("t4_count7", 64'(count), 64'd7);
    check("t4_ovf", 64'(overflow), 64'd1);
    // drain order: 11..16 then 20
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        check("t4_drain_addr", 64'(bus.wb_address), 64'(11 + i));
        check("t4_drain_data", 64'(bus.wb_data), 64'(32'h101 + i));
      end else begin
        check("t4_drain_addr", 64'(bus.wb_address), 64'd20);
        check("t4_drain_data", 64'(bus.wb_data), 64'h200);
      end
      step();
    end
    check("t4_empty", 64'(count), 64'd0);
    check("t4_ovf_sticky", 64'(overflow), 64'd1);

    // 5: wrap-around streaming after reset
    do_reset();
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_a(AW'(i), DW'(32'hA000 + i));
      step();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      check("t5_addr", 64'(bus.wb_address), 64'(i));
      check("t5_data", 64'(bus.wb_data), 64'(32'hA000 + i));
    end
    idle_in();
    step();
    check("t5_maxcount", 64'(max_cnt), 64'd1);
    check("t5_final_count", 64'(count), 64'd0);
    check("t5_ovf", 64'(overflow), 64'd0);

    // 6: reset mid-operation wins over push/pop
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_a(AW'(i), DW'(i));
      step();
    end
    idle_in();
    check("t6_count5", 64'(count), 64'd5);
    rst = 1'b1; push_a(5'd9, 32'h9); bus.wb_ready = 1'b1;
    step();
    rst = 1'b0; idle_in();
    check("t6_count", 64'(count), 64'd0);
    check("t6_valid", 64'(bus.wb_valid), 64'd0);
    check("t6_stall", 64'(stall), 64'd0);
    check("t6_ovf", 64'(overflow), 64'd0);
    step();
    check("t6_still_empty", 64'(count), 64'd0);
    check("t6_still_invalid", 64'(bus.wb_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
